mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported byte-addressed memory between the CPU instruction-fetch port and data load/store port.
- The memory follows the team's memory model:
  - registered read: data is returned on the posedge where ren is high, and is valid the following cycle;
  - write is committed on the posedge where wen is high.
- The arbiter issues at most one access per cycle, routes each response back to its owner, and guarantees fetch progress under sustained data traffic.

Parameters:
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending before one fetch grant is forced (range 1..15).
- ADDR_LIMIT, 32'h0000_0100, accesses with address + size_bytes > ADDR_LIMIT are not issued to memory; they complete with err.

Ports:
- clk  in  1  system clock; all state updates on its posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  32  fetch address (word read)
- i_ready  out  1  fetch accepted this cycle (combinational)
- i_valid  out  1  fetch response valid (registered)
- i_rdata  out  32  fetch data, meaningful while i_valid
- i_err  out  1  fetch out of range, qualifies i_valid
- d_req  in  1  data request; held with its fields stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  01 byte, 10 half, 11 word; 00 is illegal (err)
- d_addr  in  32  data address
- d_wdata  in  32  store data, low bytes used for byte/half
- d_ready  out  1  data accepted this cycle (combinational)
- d_valid  out  1  data response / store ack (registered)
- d_rdata  out  32  load data, meaningful while d_valid && !d_we-of-request
- d_err  out  1  illegal size or out of range
- mem_addr  out  32  memory address
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_size  out  2  write size to memory (11 for all reads)
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_ren

Behaviour:
- Grant decision is combinational each cycle.
  - Only d_req: grant data.
  - Only i_req: grant fetch.
  - Both pending: grant data unless streak == MAX_D_STREAK, in which case grant fetch.
- Streak counter, 4 bits:
  - increments on each data grant made while i_req=1;
  - clears on any fetch grant, or on any cycle with i_req=0;
  - saturates at MAX_D_STREAK.
- Exactly one of i_ready/d_ready is high per cycle; both are 0 when there is no request.
- Issue:
  - On a grant with a legal, in-range access, drive mem_ren (load/fetch) or mem_wen (store) with addr, size and wdata taken from the granted port in the same cycle.
  - On an illegal or out-of-range access, mem_ren = mem_wen = 0.
  - With no grant, all mem_* enables are 0; addr/size/wdata are don't-care but are driven to 0.
- Response register (owner: NONE/INST/DATA, plus err flag) is loaded on the grant edge.
  - Next cycle: owner's valid=1 and err as recorded.
  - rdata = mem_rdata for a legal read; rdata = 0 for a store or an error.
  - valid lasts exactly one cycle.
- Throughput and latency:
  - Back-to-back grants every cycle are allowed (pipelined): a new grant may be issued in the same cycle a response is presented.
  - Latency from ready to valid is 1 cycle.
- Range check: address + {1,2,4} > ADDR_LIMIT → err. Computed in 33 bits so wrap-around near 32'hFFFF_FFFF also flags err.
- Alignment is not checked; the memory handles unaligned accesses bytewise.
- Reset values: all valid, ready and err outputs 0; rdata 0; mem_ren/mem_wen 0; mem_addr/mem_size/mem_wdata 0; streak 0; owner NONE.
- Reset asserted mid-operation: the pending response is discarded and no valid follows after release. A write issued on the same edge as reset assertion is not guaranteed.
- A requester dropping req before ready is a protocol violation; behaviour is unspecified, but the arbiter must not lock up.

Test Plan:
- Single fetch: i_req, i_addr=8 → i_ready same cycle, mem_ren=1, mem_addr=8; next cycle i_valid=1, i_rdata=mem word at 8, i_err=0.
- Store then load: d_we=1, d_size=11, d_addr=4, d_wdata=32'hDEADBEEF → mem_wen=1, d_valid next cycle. Then a load at address 4 → d_rdata=32'hDEADBEEF.
- Contention: i_req and d_req held high continuously with MAX_D_STREAK=4 → grant pattern D,D,D,D,I repeating; fetch gets 1 of every 5 cycles and none is lost.
- Out of range: d_addr=32'hFE, d_size=11, ADDR_LIMIT=32'h100 → mem_wen=mem_ren=0, next cycle d_valid=1, d_err=1. Same for d_addr=32'hFFFF_FFFE (wrap).
- Illegal size: d_size=00 → no memory enable, d_valid=1 with d_err=1 next cycle.
- Reset mid-flight: grant a fetch, assert reset before the next posedge → i_valid stays 0, all outputs 0 immediately, streak 0; after release a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, the CPU fetch/data ports and the memory.
// slave = arbiter side, master = CPU + memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    input  mem_rdata,
    output i_ready, i_valid, i_rdata, i_err,
    output d_ready, d_valid, d_rdata, d_err,
    output mem_addr, mem_ren, mem_wen,
    output mem_size, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_size, d_addr, d_wdata,
    output mem_rdata,
    input  i_ready, i_valid, i_rdata, i_err,
    input  d_ready, d_valid, d_rdata, d_err,
    input  mem_addr, mem_ren, mem_wen,
    input  mem_size, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported memory.
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter logic [31:0] ADDR_LIMIT   = 32'h0000_0100
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [32:0] LIMIT33 = {1'b0, ADDR_LIMIT};

  logic [3:0]  streak_q, streak_d;
  logic [1:0]  owner_q, owner_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;

  logic        gnt_i, gnt_d;
  logic [2:0]  d_bytes;
  logic [32:0] i_end, d_end;
  logic        i_ok, d_ok;

  // 33-bit sums so accesses wrapping past 2^32 are flagged too
  always_comb begin
    d_bytes = 3'd0;
    case (bus.d_size)
      2'b01:   d_bytes = 3'd1;
      2'b10:   d_bytes = 3'd2;
      2'b11:   d_bytes = 3'd4;
      default: d_bytes = 3'd0;
    endcase
    i_end = {1'b0, bus.i_addr} + 33'd4;
    d_end = {1'b0, bus.d_addr} + {30'd0, d_bytes};
    i_ok  = (i_end <= LIMIT33);
    d_ok  = (d_bytes != 3'd0) && (d_end <= LIMIT33);
  end

  // Data wins unless it has starved a waiting fetch long enough
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      if (bus.d_req &&
          !(bus.i_req && streak_q == STREAK_MAX))
        gnt_d = 1'b1;
      else if (bus.i_req)
        gnt_i = 1'b1;
    end
  end

  always_comb begin
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_size  = 2'b00;
    bus.mem_wdata = 32'd0;
    if (gnt_i && i_ok) begin
      bus.mem_ren  = 1'b1;
      bus.mem_addr = bus.i_addr;
      bus.mem_size = 2'b11;
    end else if (gnt_d && d_ok) begin
      bus.mem_addr = bus.d_addr;
      if (bus.d_we) begin
        bus.mem_wen   = 1'b1;
        bus.mem_size  = bus.d_size;
        bus.mem_wdata = bus.d_wdata;
      end else begin
        bus.mem_ren  = 1'b1;
        bus.mem_size = 2'b11;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    if (gnt_i) begin
      owner_d = OWN_INST;
      err_d   = !i_ok;
    end else if (gnt_d) begin
      owner_d = OWN_DATA;
      err_d   = !d_ok;
    end
    rd_d = bus.mem_ren;

    streak_d = streak_q;
    if (!bus.i_req || gnt_i)
      streak_d = 4'd0;
    else if (gnt_d && streak_q != STREAK_MAX)
      streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= 4'd0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // mem_rdata is valid in the response cycle, so pass it through
  always_comb begin
    bus.i_ready = gnt_i;
    bus.d_ready = gnt_d;
    bus.i_valid = (owner_q == OWN_INST);
    bus.d_valid = (owner_q == OWN_DATA);
    bus.i_err   = bus.i_valid && err_q;
    bus.d_err   = bus.d_valid && err_q;
    bus.i_rdata = (bus.i_valid && rd_q) ? bus.mem_rdata : 32'd0;
    bus.d_rdata = (bus.d_valid && rd_q) ? bus.mem_rdata : 32'd0;
  end

endmodule
